// File: rtl/wb.sv
// ---------------------------------------------------------------------------
// wb : writeback stage of the five-stage CPU.
//
// Commits MEM-stage results to the register file, HI/LO and the CP0
// registers (Count, Status, Cause, EPC). Syscall/overflow raise an exception
// that redirects fetch to EXC_ENTRY. Eret returns to EPC. Both cases drive
// the cancel line that flushes IF/ID/EXE/MEM.
//
// Handshake: WB_valid marks a valid instruction for exactly one cycle.
// Writeback always completes in that cycle (WB_over = WB_valid), so there
// is no back-pressure. Upstream must drop WB_valid in the cycle after
// cancel.
//
// Ports
//   clk, resetn    clock, asynchronous active-low reset
//   WB_valid       instruction present in WB
//   MEM_WB_bus_r   119-bit registered MEM->WB bus
//   rf_wen/rf_wdest/rf_wdata  register-file write port
//   WB_over        WB finished this cycle
//   WB_wdest       destination for hazard detection (zero when idle)
//   exc_bus        {exc_valid, exc_pc} to fetch
//   cancel         flush of upstream stages
//   WB_pc          pc of the instruction in WB
//   HI_data/LO_data  current HI and LO
// ---------------------------------------------------------------------------
module wb #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_0008
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         WB_valid,
  input  logic [118:0] MEM_WB_bus_r,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic [32:0]  exc_bus,
  output logic         cancel,
  output logic [31:0]  WB_pc,
  output logic [31:0]  HI_data,
  output logic [31:0]  LO_data
);

  // CP0 addresses are {rd, sel}.
  localparam logic [7:0] ADDR_COUNT  = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC    = {5'd14, 3'd0};

  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Bus fields
  logic        w_rf_wen_bus;
  logic [4:0]  w_rf_wdest;
  logic [31:0] w_mem_result;
  logic [31:0] w_lo_result;
  logic        w_hi_write;
  logic        w_lo_write;
  logic        w_mfhi;
  logic        w_mflo;
  logic        w_mtc0;
  logic        w_mfc0;
  logic [7:0]  w_cp0r_addr;
  logic        w_syscall;
  logic        w_eret;
  logic        w_overflow;
  logic [31:0] w_pc;

  assign {w_rf_wen_bus, w_rf_wdest, w_mem_result, w_lo_result,
          w_hi_write, w_lo_write, w_mfhi, w_mflo, w_mtc0, w_mfc0,
          w_cp0r_addr, w_syscall, w_eret, w_overflow, w_pc} = MEM_WB_bus_r;

  // Architectural state
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_count;
  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic [1:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  // Qualifiers
  logic w_exc;
  logic w_commit;
  logic w_eret_take;
  logic w_mtc0_take;

  assign w_exc       = WB_valid & (w_syscall | w_overflow);
  assign w_commit    = WB_valid & ~w_exc;
  assign w_eret_take = WB_valid & w_eret & ~w_exc;
  assign w_mtc0_take = w_commit & w_mtc0;

  // Register views with unimplemented bits forced to zero
  logic [31:0] w_status;
  logic [31:0] w_cause;

  assign w_status = {16'b0, r_status_im, 6'b0, r_status_exl, r_status_ie};
  assign w_cause  = {22'b0, r_cause_ip, 1'b0, r_cause_exc, 2'b0};

  logic [31:0] w_cp0_rdata;

  always_comb begin
    w_cp0_rdata = 32'b0;
    case (w_cp0r_addr)
      ADDR_COUNT:  w_cp0_rdata = r_count;
      ADDR_STATUS: w_cp0_rdata = w_status;
      ADDR_CAUSE:  w_cp0_rdata = w_cause;
      ADDR_EPC:    w_cp0_rdata = r_epc;
      default:     w_cp0_rdata = 32'b0;
    endcase
  end

  // Register-file port
  always_comb begin
    rf_wdata = w_mem_result;
    if (w_mfhi)      rf_wdata = r_hi;
    else if (w_mflo) rf_wdata = r_lo;
    else if (w_mfc0) rf_wdata = w_cp0_rdata;
  end

  assign rf_wen   = w_rf_wen_bus & w_commit;
  assign rf_wdest = w_rf_wdest;
  assign WB_wdest = w_rf_wdest & {5{WB_valid}};
  assign WB_over  = WB_valid;
  assign WB_pc    = w_pc;
  assign HI_data  = r_hi;
  assign LO_data  = r_lo;

  // Exception / eret redirect. Eret uses the pre-edge EPC.
  logic        w_exc_valid;
  logic [31:0] w_exc_pc;

  always_comb begin
    w_exc_valid = 1'b0;
    w_exc_pc    = 32'b0;
    if (w_exc) begin
      w_exc_valid = 1'b1;
      w_exc_pc    = EXC_ENTRY;
    end else if (w_eret_take) begin
      w_exc_valid = 1'b1;
      w_exc_pc    = r_epc;
    end
  end

  assign exc_bus = {w_exc_valid, w_exc_pc};
  assign cancel  = w_exc_valid;

  // HI / LO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= 32'b0;
      r_lo <= 32'b0;
    end else begin
      if (w_commit & w_hi_write) r_hi <= w_mem_result;
      if (w_commit & w_lo_write) r_lo <= w_lo_result;
    end
  end

  // Count: free-running, an mtc0 load takes precedence over the increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= 32'b0;
    end else if (w_mtc0_take && (w_cp0r_addr == ADDR_COUNT)) begin
      r_count <= w_mem_result;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

  // Status. Exception entry sets EXL, eret clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status_im  <= 8'b0;
      r_status_exl <= 1'b0;
      r_status_ie  <= 1'b0;
    end else begin
      if (w_mtc0_take && (w_cp0r_addr == ADDR_STATUS)) begin
        r_status_im  <= w_mem_result[15:8];
        r_status_exl <= w_mem_result[1];
        r_status_ie  <= w_mem_result[0];
      end
      if (w_exc)            r_status_exl <= 1'b1;
      else if (w_eret_take) r_status_exl <= 1'b0;
    end
  end

  // Cause: software writes only IP, hardware writes ExcCode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cause_ip  <= 2'b0;
      r_cause_exc <= 5'b0;
    end else begin
      if (w_mtc0_take && (w_cp0r_addr == ADDR_CAUSE))
        r_cause_ip <= w_mem_result[9:8];
      if (w_exc)
        r_cause_exc <= w_syscall ? EXC_SYS : EXC_OV;
    end
  end

  // EPC: a nested exception (EXL already set) keeps the original return PC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_epc <= 32'b0;
    end else if (w_exc) begin
      if (!r_status_exl) r_epc <= w_pc;
    end else if (w_mtc0_take && (w_cp0r_addr == ADDR_EPC)) begin
      r_epc <= w_mem_result;
    end
  end

endmodule

// File: doc/wb.md
# wb

Writeback stage of the five-stage CPU, directly downstream of the memory-access stage. It consumes the 119-bit MEM->WB bus and commits results to the register file, HI/LO and the CP0 registers. The CP0 registers are Status, Cause, EPC and Count. It also handles syscall, overflow and eret, and drives the exception/cancel bus that redirects fetch and flushes upstream stages.

## Interface
Parameters:
- EXC_ENTRY, 32'h0000_0008, exception handler PC for syscall and overflow.

Ports:
- clk  in  1  clock. One clock domain.
- resetn  in  1  asynchronous, active-low reset.
- WB_valid  in  1  the WB stage holds a valid instruction.
- MEM_WB_bus_r  in  119  registered MEM->WB bus. Field order, MSB first:
  - rf_wen[1], rf_wdest[5], mem_result[32], lo_result[32]
  - hi_write, lo_write, mfhi, mflo, mtc0, mfc0
  - cp0r_addr[8] = {rd, sel}
  - syscall, eret, overflow, pc[32]
- rf_wen  out  1  register-file write enable.
- rf_wdest  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- WB_over  out  1  WB finished this cycle.
- WB_wdest  out  5  rf_wdest & {5{WB_valid}}, for hazard detection.
- exc_bus  out  33  {exc_valid, exc_pc}, to fetch.
- cancel  out  1  flush IF/ID/EXE/MEM.
- WB_pc  out  32  pc field, for display.
- HI_data, LO_data  out  32 each  current HI and LO, for display.

## Operation
Definitions:
- exc = WB_valid & (syscall | overflow).
- commit = WB_valid & ~exc.

An excepting instruction commits no architectural state: no register-file write, no HI/LO write, no mtc0.

Register file:
- rf_wen = rf_wen_bus & commit.
- rf_wdest = rf_wdest field.
- rf_wdata priority: mfhi -> HI; else mflo -> LO; else mfc0 -> cp0_rdata; else mem_result.

HI/LO:
- commit & hi_write: HI <= mem_result.
- commit & lo_write: LO <= lo_result.
- Both may be written in the same cycle (mult).

CP0 addresses (cp0r_addr):
- Count = {9,0}
- Status = {12,0}
- Cause = {13,0}
- EPC = {14,0}
- mfc0 of any other address reads 0. mtc0 to any other address is ignored.

Status:
- Implemented bits: [15:8] IM, [1] EXL, [0] IE. All other bits read 0.
- mtc0 writes the implemented bits.

Cause:
- Implemented bits: [9:8] IP (software), [6:2] ExcCode. All other bits read 0.
- mtc0 writes [9:8] only.

EPC:
- Full 32 bits, writable by mtc0.

Count:
- Increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
- mtc0 Count loads mem_result. A write wins over that cycle's increment.

Exception entry (exc):
- ExcCode <= 8 (Sys) for syscall, 12 (Ov) for overflow. If both are set, syscall wins.
- If Status.EXL == 0: EPC <= pc.
- If Status.EXL == 1: EPC is unchanged.
- Status.EXL <= 1.
- exc_valid = 1, exc_pc = EXC_ENTRY.

eret (WB_valid & eret & ~exc):
- Status.EXL <= 0.
- exc_valid = 1, exc_pc = current EPC, i.e. the pre-edge value.

Cancel and completion:
- cancel = exc_valid.
- WB_over = WB_valid.
- Writeback completes in one cycle.

## Timing
- All outputs except HI_data/LO_data are combinational from the bus, WB_valid and current registers.
- All state updates happen on the rising clk edge after the qualifying cycle.
- An mfc0/mfhi/mflo in the cycle after an mtc0/mthi/mult reads the new value. No bypass is needed inside WB.
- mfc0 Count returns the pre-edge value.
- exc_valid/cancel assert for exactly the single WB_valid cycle of the causing instruction. Upstream must drop WB_valid next cycle.
- When WB_valid = 0: rf_wen = 0, exc_valid = 0, cancel = 0, and no state changes except the Count increment.
- Reset (resetn low, asynchronous) clears HI, LO, Status, Cause, EPC and Count to 0. Reset mid-operation abandons any in-flight commit.
- Reset output values: rf_wen = 0, exc_valid = 0, cancel = 0, WB_over = WB_valid.

## Test plan
- **Reset:** assert resetn = 0 mid-count, then release. Expect HI/LO/Status/Cause/EPC = 0 and Count counting from 0 (Count = 3 three cycles after release).
- **mult then reads:** commit mult with hi_write = lo_write = 1, mem_result = 32'h1, lo_result = 32'h2. Follow with mfhi to r8, then mflo to r9. Expect rf_wdata = 1 then 2, with rf_wen high both cycles.
- **syscall:** at pc = 32'hBFC0_0100 with Status = 0. Expect exc_bus = {1, 32'h8}, cancel = 1, EPC = 32'hBFC0_0100, Cause[6:2] = 8, EXL = 1. Then eret: exc_pc = 32'hBFC0_0100, EXL = 0.
- **overflow:** with rf_wen = 1, rf_wdest = 5, hi_write = 1. Expect rf_wen = 0, HI unchanged, Cause[6:2] = 12.
- **Nested syscall:** syscall while EXL = 1 at pc = 32'h200. Expect EPC unchanged and exc_pc = 32'h8.
- **mtc0 Count:** mtc0 Count = 32'hFFFF_FFFE, then idle 2 cycles. Expect mfc0 Count reads 32'hFFFF_FFFF then 32'h0 (wrap); the write beats the increment on the mtc0 edge.
